// File: rtl/bit_clk_pkg.sv
// Shared constants and enums for the serial bit-stream transmitter.
package bit_clk_pkg;

    localparam int unsigned CLK_LEN      = 32;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned PREAMBLE_LEN = 16;
    localparam int unsigned MIN_PERIOD   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } tx_state_e;

    typedef enum logic {
        NRZ        = 1'b0,
        MANCHESTER = 1'b1
    } line_code_e;

endpackage

// File: rtl/bit_stream_tx_timer.sv
// Bit timer: latches the clamped bit period at frame start and counts 0..P-1.
// The *_nx flags describe the next count so the caller can register its outputs.
module bit_timer #(
    parameter int unsigned CLK_LEN    = bit_clk_pkg::CLK_LEN,
    parameter int unsigned MIN_PERIOD = bit_clk_pkg::MIN_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               run,
    input  logic [CLK_LEN-1:0] bit_period,
    output logic               wrap,
    output logic               strobe_nx,
    output logic               half_nx,
    output logic               last_nx
);

    logic [CLK_LEN-1:0] period_q, period_d;
    logic [CLK_LEN-1:0] cnt_q, cnt_d;

    function automatic logic [CLK_LEN-1:0] clamp_period(input logic [CLK_LEN-1:0] p);
        if (p < CLK_LEN'(MIN_PERIOD)) begin
            return CLK_LEN'(MIN_PERIOD);
        end else begin
            return p;
        end
    endfunction

    assign wrap = (cnt_q == period_q - CLK_LEN'(1));

    // Period latch and wrapping counter, next values.
    always_comb begin
        period_d = period_q;
        cnt_d    = '0;
        if (load) begin
            period_d = clamp_period(bit_period);
            cnt_d    = '0;
        end else if (run) begin
            cnt_d = wrap ? '0 : cnt_q + CLK_LEN'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Flags for the count that becomes current after the next edge.
    always_comb begin
        strobe_nx = (cnt_d == '0);
        half_nx   = (cnt_d >= (period_d >> 1));
        last_nx   = (cnt_d == period_d - CLK_LEN'(1));
    end

    // Counter and period registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_stream_tx.sv
// Serial transmitter: alternating preamble then MSB-first payload, NRZ or Manchester,
// with back-to-back bytes accepted on the last cycle of the final data bit.
module bit_stream_tx #(
    parameter int unsigned CLK_LEN      = bit_clk_pkg::CLK_LEN,
    parameter int unsigned DATA_W       = bit_clk_pkg::DATA_W,
    parameter int unsigned PREAMBLE_LEN = bit_clk_pkg::PREAMBLE_LEN,
    parameter int unsigned MIN_PERIOD   = bit_clk_pkg::MIN_PERIOD
) (
    input  logic               clk_300M,
    input  logic               rst,
    input  logic [CLK_LEN-1:0] bit_period,
    input  logic               manchester,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               signal_out,
    output logic               bit_strobe,
    output logic               busy
);
    import bit_clk_pkg::*;

    localparam int unsigned IDX_MAX = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
    localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    tx_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    line_code_e         manch_q, manch_d;
    logic               signal_out_q, signal_out_d;
    logic               bit_strobe_q, bit_strobe_d;
    logic               busy_q, busy_d;
    logic               tx_ready_q, tx_ready_d;
    logic               xfer_s, load_s, run_s, line_bit_s;
    logic               wrap_s, strobe_nx_s, half_nx_s, last_nx_s;

    assign xfer_s = tx_valid & tx_ready_q;
    assign load_s = (state_q == IDLE) & xfer_s;
    assign run_s  = (state_q != IDLE);

    bit_timer #(
        .CLK_LEN    (CLK_LEN),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_bit_timer (
        .clk        (clk_300M),
        .rst        (rst),
        .load       (load_s),
        .run        (run_s),
        .bit_period (bit_period),
        .wrap       (wrap_s),
        .strobe_nx  (strobe_nx_s),
        .half_nx    (half_nx_s),
        .last_nx    (last_nx_s)
    );

    // State register; outputs are registered from next-state decode so they align with state.
    always_ff @(posedge clk_300M or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shreg_q      <= '0;
            manch_q      <= NRZ;
            signal_out_q <= 1'b0;
            bit_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            tx_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            manch_q      <= manch_d;
            signal_out_q <= signal_out_d;
            bit_strobe_q <= bit_strobe_d;
            busy_q       <= busy_d;
            tx_ready_q   <= tx_ready_d;
        end
    end

    // Next-state, bit index and shifter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        manch_d = manch_q;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    state_d = PREAMBLE;
                    idx_d   = '0;
                    shreg_d = tx_data;
                    manch_d = line_code_e'(manchester);
                end else begin
                    state_d = IDLE;
                end
            end
            PREAMBLE: begin
                if (!wrap_s) begin
                    idx_d = idx_q;
                end else if (idx_q == IDX_W'(PREAMBLE_LEN - 1)) begin
                    state_d = DATA;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DATA: begin
                if (!wrap_s) begin
                    idx_d = idx_q;
                end else if (idx_q != IDX_W'(DATA_W - 1)) begin
                    idx_d   = idx_q + IDX_W'(1);
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                end else if (xfer_s) begin
                    idx_d   = '0;
                    shreg_d = tx_data;
                end else begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output decode of the next state; Manchester inverts the bit in the first half.
    always_comb begin
        case (state_d)
            PREAMBLE: line_bit_s = ~idx_d[0];
            DATA:     line_bit_s = shreg_d[DATA_W-1];
            default:  line_bit_s = 1'b0;
        endcase
        if (state_d == IDLE) begin
            signal_out_d = 1'b0;
        end else if (manch_d == MANCHESTER) begin
            signal_out_d = half_nx_s ? line_bit_s : ~line_bit_s;
        end else begin
            signal_out_d = line_bit_s;
        end
        busy_d       = (state_d != IDLE);
        bit_strobe_d = (state_d != IDLE) & strobe_nx_s;
        tx_ready_d   = (state_d == IDLE) |
                       ((state_d == DATA) & (idx_d == IDX_W'(DATA_W - 1)) & last_nx_s);
    end

    assign tx_ready   = tx_ready_q;
    assign signal_out = signal_out_q;
    assign bit_strobe = bit_strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bit_stream_tx.sv
// Self-checking bench: per-cycle expected line built from the framing rules, directed and random frames.
`timescale 1ns/1ps
module tb_bit_stream_tx;

    logic        clk_300M = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bit_period = 32'd0;
    logic        manchester = 1'b0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, signal_out, bit_strobe, busy;

    int checks = 0;
    int errors = 0;

    bit_stream_tx dut (
        .clk_300M   (clk_300M),
        .rst        (rst),
        .bit_period (bit_period),
        .manchester (manchester),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .signal_out (signal_out),
        .bit_strobe (bit_strobe),
        .busy       (busy)
    );

    always #5 clk_300M = ~clk_300M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_300M);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        check({tag, " signal_out"}, signal_out, 1'b0);
        check({tag, " bit_strobe"}, bit_strobe, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " tx_ready"}, tx_ready, exp_ready);
    endtask

    // One frame of nb bytes; abort_at >= 0 pulses reset at that frame cycle instead of finishing.
    task automatic run_frame(input logic [31:0] bp, input logic man, input int nb,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int abort_at);
        logic [7:0] bytes [3];
        bit sig_q[$];
        bit stb_q[$];
        bit rdy_q[$];
        int p;
        int j;
        bit b;
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        p = (bp < 32'd4) ? 4 : int'(bp);
        for (int i = 0; i < 16; i++) begin
            b = (i % 2 == 0);
            for (int c = 0; c < p; c++) begin
                sig_q.push_back(man ? ((c < p / 2) ? !b : b) : b);
                stb_q.push_back(c == 0);
                rdy_q.push_back(1'b0);
            end
        end
        for (int n = 0; n < nb; n++) begin
            for (int bi = 7; bi >= 0; bi--) begin
                b = bytes[n][bi];
                for (int c = 0; c < p; c++) begin
                    sig_q.push_back(man ? ((c < p / 2) ? !b : b) : b);
                    stb_q.push_back(c == 0);
                    rdy_q.push_back(bi == 0 && c == p - 1);
                end
            end
        end

        tx_valid   = 1'b1;
        tx_data    = b0;
        bit_period = bp;
        manchester = man;
        j = 0;
        for (int k = 0; k < sig_q.size(); k++) begin
            tick();
            if (k == abort_at) begin
                rst = 1'b1;
                tx_valid = 1'b0;
                #1;
                check_idle("async reset", 1'b0);
                tick();
                tick();
                check_idle("held reset", 1'b0);
                #3;
                rst = 1'b0;
                #1;
                check("tx_ready before first clock", tx_ready, 1'b0);
                tick();
                check_idle("after reset release", 1'b1);
                return;
            end
            check("signal_out", signal_out, sig_q[k]);
            check("bit_strobe", bit_strobe, stb_q[k]);
            check("busy", busy, 1'b1);
            check("tx_ready", tx_ready, rdy_q[k]);
            if (rdy_q[k]) begin
                j++;
                if (j < nb) begin
                    tx_valid = 1'b1;
                    tx_data  = bytes[j];
                end else begin
                    tx_valid = 1'b0;
                end
            end else begin
                tx_valid   = 1'($urandom_range(0, 1));
                tx_data    = 8'($urandom);
                bit_period = 32'($urandom_range(0, 12));
                manchester = 1'($urandom_range(0, 1));
            end
        end
        tick();
        check_idle("frame end", 1'b1);
    endtask

    initial begin
        #1;
        check_idle("in reset", 1'b0);
        tick();
        tick();
        check_idle("in reset clocked", 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("tx_ready after release", tx_ready, 1'b0);
        tick();
        check_idle("first clock", 1'b1);

        run_frame(32'd6, 1'b0, 1, 8'hA5, 8'h00, 8'h00, -1);
        run_frame(32'd5, 1'b0, 2, 8'h3C, 8'hC3, 8'h00, -1);
        run_frame(32'd7, 1'b1, 1, 8'h01, 8'h00, 8'h00, -1);
        run_frame(32'd2, 1'b0, 1, 8'h96, 8'h00, 8'h00, -1);
        run_frame(32'd0, 1'b1, 1, 8'h69, 8'h00, 8'h00, -1);
        run_frame(32'd6, 1'b0, 1, 8'hE1, 8'h00, 8'h00, -1);
        run_frame(32'd10, 1'b0, 1, 8'h1E, 8'h00, 8'h00, -1);
        run_frame(32'd6, 1'b0, 1, 8'h5A, 8'h00, 8'h00, 16 * 6 + 3 * 6 + 2);
        run_frame(32'd6, 1'b0, 1, 8'hB4, 8'h00, 8'h00, -1);
        run_frame(32'd9, 1'b1, 3, 8'hFF, 8'h00, 8'h81, -1);

        for (int r = 0; r < 10; r++) begin
            run_frame(32'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 3)),
                      8'($urandom), 8'($urandom), 8'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
